// File: rtl/uart_tx_periph_if.sv
// CPU data-bus slice seen by the UART transmitter: decoder select, write strobe,
// register offset, write data and the combinational read-data return path.
interface uart_tx_periph_if;
    logic        sel;
    logic        busWe;
    logic [3:0]  busAddr;
    logic [31:0] busWData;
    logic [31:0] busRData;

    modport master (
        output sel, busWe, busAddr, busWData,
        input  busRData
    );

    modport slave (
        input  sel, busWe, busAddr, busWData,
        output busRData
    );
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and programmable baud divisor.
// Define UART_TX_PARITY_EN to add a parity bit (CTRL[2]: 0=even, 1=odd) before the stop bit.
module uart_tx_periph #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_RESET  = 868
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_periph_if.slave  bus,
    output logic             txd,
    output logic             txIrq
);
    localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t      r_state, w_nextState;
    logic [7:0]  r_fifo [FIFO_DEPTH];
    logic [AW:0] r_wrPtr, r_rdPtr, w_count;
    logic        w_full, w_empty, w_wr, w_push, w_pop, w_accept;
    logic        w_baudDone, w_txdNext, w_ctrlOdd, w_unused;
    logic [1:0]  w_regSel;
    logic [7:0]  w_head, r_shift;
    logic [15:0] r_div, r_divLat, r_baudCnt;
    logic [2:0]  r_bitIdx;
    logic        r_ovf, r_ie, r_txen, r_txd;
    logic [31:0] w_rdata;
`ifdef UART_TX_PARITY_EN
    logic        r_parOdd, r_parityBit;
    assign w_ctrlOdd = r_parOdd;
    assign w_unused  = ^{bus.busWData[31:16], bus.busAddr[1:0]};
`else
    assign w_ctrlOdd = 1'b0;
    assign w_unused  = ^{bus.busWData[31:16], bus.busWData[2], bus.busAddr[1:0]};
`endif

    assign w_regSel   = bus.busAddr[3:2];
    assign w_wr       = bus.sel & bus.busWe;
    assign w_push     = w_wr & (w_regSel == 2'd0);
    assign w_count    = r_wrPtr - r_rdPtr;
    assign w_empty    = (r_wrPtr == r_rdPtr);
    assign w_full     = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign w_accept   = w_push & (~w_full | w_pop);
    assign w_head     = r_fifo[r_rdPtr[AW-1:0]];
    assign w_baudDone = (r_baudCnt == r_divLat - 16'd1);
    assign txd        = r_txd;
    assign txIrq      = w_empty & (r_state == S_IDLE) & r_ie;

    always_ff @(posedge clk) begin
        if (w_accept)
            r_fifo[r_wrPtr[AW-1:0]] <= bus.busWData[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_ovf   <= 1'b0;
            r_div   <= 16'(DIV_RESET);
            r_ie    <= 1'b0;
            r_txen  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parOdd <= 1'b0;
`endif
        end else begin
            if (w_accept)
                r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)
                r_rdPtr <= r_rdPtr + 1'b1;
            if (w_push & w_full & ~w_pop)
                r_ovf <= 1'b1;
            else if (w_wr && (w_regSel == 2'd1) && bus.busWData[3])
                r_ovf <= 1'b0;
            if (w_wr && (w_regSel == 2'd2))
                r_div <= (bus.busWData[15:0] == 16'd0) ? 16'd1 : bus.busWData[15:0];
            if (w_wr && (w_regSel == 2'd3)) begin
                r_ie   <= bus.busWData[0];
                r_txen <= bus.busWData[1];
`ifdef UART_TX_PARITY_EN
                r_parOdd <= bus.busWData[2];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_nextState;
    end

    // The divisor is sampled at pop time so a DIV write never stretches a frame in flight.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_txdNext   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (r_txen && !w_empty) begin
                    w_pop       = 1'b1;
                    w_nextState = S_START;
                end
            end
            S_START: begin
                w_txdNext = 1'b0;
                if (w_baudDone)
                    w_nextState = S_DATA;
            end
            S_DATA: begin
                w_txdNext = r_shift[0];
                if (w_baudDone && (r_bitIdx == 3'd7))
`ifdef UART_TX_PARITY_EN
                    w_nextState = S_PARITY;
`else
                    w_nextState = S_STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_txdNext = r_parityBit;
                if (w_baudDone)
                    w_nextState = S_STOP;
            end
`endif
            S_STOP: begin
                w_txdNext = 1'b1;
                if (w_baudDone) begin
                    if (r_txen && !w_empty) begin
                        w_pop       = 1'b1;
                        w_nextState = S_START;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_txd     <= 1'b1;
            r_shift   <= 8'd0;
            r_divLat  <= 16'(DIV_RESET);
            r_baudCnt <= 16'd0;
            r_bitIdx  <= 3'd0;
`ifdef UART_TX_PARITY_EN
            r_parityBit <= 1'b0;
`endif
        end else begin
            r_txd <= w_txdNext;
            if (w_pop) begin
                r_shift   <= w_head;
                r_divLat  <= r_div;
                r_baudCnt <= 16'd0;
                r_bitIdx  <= 3'd0;
`ifdef UART_TX_PARITY_EN
                r_parityBit <= (^w_head) ^ r_parOdd;
`endif
            end else if (r_state != S_IDLE) begin
                if (w_baudDone) begin
                    r_baudCnt <= 16'd0;
                    if (r_state == S_DATA) begin
                        r_shift  <= r_shift >> 1;
                        r_bitIdx <= r_bitIdx + 3'd1;
                    end
                end else begin
                    r_baudCnt <= r_baudCnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_regSel)
            2'd1:    w_rdata = {25'd0, 3'(w_count), r_ovf, (r_state != S_IDLE), w_empty, w_full};
            2'd2:    w_rdata = {16'd0, r_div};
            2'd3:    w_rdata = {29'd0, w_ctrlOdd, r_txen, r_ie};
            default: w_rdata = 32'd0;
        endcase
        bus.busRData = bus.sel ? w_rdata : 32'd0;
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: register vector table, a serial-line monitor fed by a
// frame scoreboard, and hand sequences for latency, overflow, back-to-back and reset.
module tb_uart_tx_periph;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS   = 11;
    localparam logic [31:0] CTRL_RW = 32'h7;
`else
    localparam int          NBITS   = 10;
    localparam logic [31:0] CTRL_RW = 32'h3;
`endif

    typedef struct {
        logic [7:0] data;
        int         bitLen;
        logic       odd;
    } frame_t;

    typedef struct {
        logic        doWrite;
        logic [3:0]  wrAddr;
        logic [31:0] wdata;
        logic [3:0]  rdAddr;
        logic [31:0] expRead;
    } vec_t;

    logic clk;
    logic reset;
    logic txd;
    logic txIrq;
    int   testsRun;
    int   testsFailed;
    int   cycle;
    int   lastStart;
    int   prevStart;
    bit   monEnable;
    bit   monBusy;
    frame_t sb[$];
    vec_t   vecs[11];

    uart_tx_periph_if busIf();

    uart_tx_periph dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf),
        .txd   (txd),
        .txIrq (txIrq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic busWrite(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        busIf.sel      = 1'b1;
        busIf.busWe    = 1'b1;
        busIf.busAddr  = addr;
        busIf.busWData = data;
        @(posedge clk);
        #1;
        busIf.sel   = 1'b0;
        busIf.busWe = 1'b0;
    endtask

    task automatic busRead(input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk);
        busIf.sel     = 1'b1;
        busIf.busWe   = 1'b0;
        busIf.busAddr = addr;
        #1;
        data      = busIf.busRData;
        busIf.sel = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [31:0] rd;
        if (v.doWrite)
            busWrite(v.wrAddr, v.wdata);
        busRead(v.rdAddr, rd);
        checkOutput($sformatf("vec%0d", idx), rd, v.expRead);
    endtask

    task automatic readCheck(input string name, input logic [3:0] addr, input logic [31:0] expected);
        logic [31:0] rd;
        busRead(addr, rd);
        checkOutput(name, rd, expected);
    endtask

    // Counts cycles with STAT.busy set until busy falls again; -1 when the bound expires.
    task automatic countBusy(input int maxCycles, output int cnt);
        logic [31:0] s;
        bit seen;
        seen = 1'b0;
        cnt  = 0;
        for (int i = 0; i < maxCycles; i++) begin
            busRead(4'h4, s);
            if (s[2]) begin
                seen = 1'b1;
                cnt++;
            end else if (seen) begin
                return;
            end
        end
        cnt = -1;
    endtask

    task automatic waitFrames(input int maxCycles);
        int n;
        n = 0;
        while ((sb.size() != 0 || monBusy) && n < maxCycles) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drain", {31'd0, (n >= maxCycles)}, 32'd0);
    endtask

    function automatic frame_t mkFrame(input logic [7:0] d, input int len, input logic odd);
        frame_t f;
        f.data   = d;
        f.bitLen = len;
        f.odd    = odd;
        return f;
    endfunction

    // Serial monitor: every sample of every bit must match the scoreboard frame.
    initial begin
        frame_t      exp;
        logic [10:0] expBits;
        logic [10:0] obsBits;
        int          bad;
        monBusy = 1'b0;
        forever begin
            @(negedge clk);
            if (monEnable && reset && txd === 1'b0) begin
                monBusy   = 1'b1;
                prevStart = lastStart;
                lastStart = cycle;
                if (sb.size() == 0) begin
                    checkOutput("unexpected frame", 32'd1, 32'd0);
                    exp = mkFrame(8'h00, 1, 1'b0);
                end else begin
                    exp = sb.pop_front();
                end
                expBits      = '0;
                expBits[0]   = 1'b0;
                expBits[8:1] = exp.data;
                if (NBITS == 11) begin
                    expBits[9]  = exp.odd ? ~(^exp.data) : ^exp.data;
                    expBits[10] = 1'b1;
                end else begin
                    expBits[9] = 1'b1;
                end
                obsBits = '0;
                bad     = 0;
                for (int b = 0; b < NBITS; b++) begin
                    for (int c = 0; c < exp.bitLen; c++) begin
                        if (b != 0 || c != 0)
                            @(negedge clk);
                        if (c == 0)
                            obsBits[b] = txd;
                        else if (txd !== obsBits[b])
                            bad++;
                    end
                end
                checkOutput($sformatf("frame 0x%02h bits", exp.data),
                            {5'd0, 16'(bad), obsBits}, {21'd0, expBits});
                monBusy = 1'b0;
            end
        end
    end

    initial begin
        int cN;
        int busyCnt;
        testsRun       = 0;
        testsFailed    = 0;
        cycle          = 0;
        lastStart      = 0;
        prevStart      = 0;
        monEnable      = 1'b1;
        busIf.sel      = 1'b0;
        busIf.busWe    = 1'b0;
        busIf.busAddr  = 4'h0;
        busIf.busWData = 32'd0;
        reset          = 1'b0;

        vecs[0]  = '{1'b0, 4'h0, 32'h0,        4'h4, 32'h2};
        vecs[1]  = '{1'b0, 4'h0, 32'h0,        4'h8, 32'd868};
        vecs[2]  = '{1'b0, 4'h0, 32'h0,        4'hC, 32'h2};
        vecs[3]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0};
        vecs[4]  = '{1'b1, 4'h8, 32'h0,        4'h8, 32'h1};
        vecs[5]  = '{1'b1, 4'h8, 32'h12345678, 4'h8, 32'h5678};
        vecs[6]  = '{1'b1, 4'hC, 32'h7,        4'hC, CTRL_RW};
        vecs[7]  = '{1'b1, 4'hC, 32'h2,        4'hC, 32'h2};
        vecs[8]  = '{1'b1, 4'h9, 32'hA,        4'hB, 32'hA};
        vecs[9]  = '{1'b1, 4'h4, 32'h8,        4'h4, 32'h2};
        vecs[10] = '{1'b1, 4'h8, 32'h4,        4'hA, 32'h4};

        #12;
        checkOutput("reset txd", {31'd0, txd}, 32'd1);
        checkOutput("reset txIrq", {31'd0, txIrq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++)
            applyStimulus(vecs[i], i);

        // An unselected write must not land, and an unselected read returns 0.
        @(negedge clk);
        busIf.sel      = 1'b0;
        busIf.busWe    = 1'b1;
        busIf.busAddr  = 4'h8;
        busIf.busWData = 32'h55;
        #1;
        checkOutput("sel0 read", busIf.busRData, 32'd0);
        @(posedge clk);
        #1;
        busIf.busWe = 1'b0;
        readCheck("sel0 write ignored", 4'h8, 32'h4);

        // Single byte, DIV=4: latency, busy length and line pattern.
        sb.push_back(mkFrame(8'hA5, 4, 1'b0));
        busWrite(4'h0, 32'hA5);
        cN = cycle;
        countBusy(500, busyCnt);
        checkOutput("single busy cycles", busyCnt, NBITS * 4);
        checkOutput("start latency", lastStart - cN, 32'd2);
        waitFrames(500);
        readCheck("single stat after", 4'h4, 32'h2);

        // Back-to-back frames at DIV=2 with no idle gap.
        busWrite(4'h8, 32'h2);
        sb.push_back(mkFrame(8'h00, 2, 1'b0));
        sb.push_back(mkFrame(8'hFF, 2, 1'b0));
        busWrite(4'h0, 32'h00);
        busWrite(4'h0, 32'hFF);
        countBusy(500, busyCnt);
        checkOutput("b2b busy cycles", busyCnt, NBITS * 4);
        waitFrames(500);
        checkOutput("b2b start spacing", lastStart - prevStart, NBITS * 2);

        // Overflow with TXEN=0, then a push into a full FIFO alongside a pop.
        busWrite(4'hC, 32'h0);
        for (int i = 1; i <= 5; i++)
            busWrite(4'h0, 32'(i * 8'h11));
        readCheck("ovf stat", 4'h4, 32'h49);
        busWrite(4'h4, 32'h8);
        readCheck("ovf cleared", 4'h4, 32'h41);
        for (int i = 1; i <= 4; i++)
            sb.push_back(mkFrame(8'(i * 8'h11), 2, 1'b0));
        sb.push_back(mkFrame(8'h5A, 2, 1'b0));
        busWrite(4'hC, 32'h2);
        busWrite(4'h0, 32'h5A);
        readCheck("full push with pop", 4'h4, 32'h45);
        waitFrames(2000);
        readCheck("ovf drained", 4'h4, 32'h2);

        // A DIV change mid-frame only affects the following frame.
        busWrite(4'h8, 32'h8);
        sb.push_back(mkFrame(8'h3C, 8, 1'b0));
        sb.push_back(mkFrame(8'hC3, 3, 1'b0));
        busWrite(4'h0, 32'h3C);
        busWrite(4'h0, 32'hC3);
        repeat (20) @(posedge clk);
        busWrite(4'h8, 32'h3);
        readCheck("div midframe readback", 4'h8, 32'h3);
        waitFrames(2000);
        checkOutput("div frame1 spacing", lastStart - prevStart, NBITS * 8);

        // Interrupt enable plus odd parity on byte 0x03.
        busWrite(4'h8, 32'h2);
        busWrite(4'hC, 32'h7);
        #1;
        checkOutput("irq idle", {31'd0, txIrq}, 32'd1);
        readCheck("ctrl odd", 4'hC, CTRL_RW);
        sb.push_back(mkFrame(8'h03, 2, 1'b1));
        busWrite(4'h0, 32'h03);
        checkOutput("irq after push", {31'd0, txIrq}, 32'd0);
        countBusy(500, busyCnt);
        checkOutput("parity busy cycles", busyCnt, NBITS * 2);
        waitFrames(500);
        @(posedge clk);
        #1;
        checkOutput("irq after frame", {31'd0, txIrq}, 32'd1);

        // Reset in the middle of a frame forces the line idle at once.
        monEnable = 1'b0;
        busWrite(4'h0, 32'h00);
        repeat (8) @(posedge clk);
        #3;
        checkOutput("midframe txd low", {31'd0, txd}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("reset txd immediate", {31'd0, txd}, 32'd1);
        checkOutput("reset txIrq immediate", {31'd0, txIrq}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        readCheck("post reset stat", 4'h4, 32'h2);
        readCheck("post reset div", 4'h8, 32'd868);
        readCheck("post reset ctrl", 4'hC, 32'h2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
